// File: rtl/gpu_instruction_encoder.sv
// Turns draw requests into set_xy/draw/reset command beats for the GPU,
// skipping coordinate beats that repeat the last ones sent.
`ifndef WIDTH_BITS
`define WIDTH_BITS 12
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 12
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_instruction_encoder (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid_i,
    input  logic [1:0]               shape_i,
    input  logic [`WIDTH_BITS-1:0]   x1_i,
    input  logic [`WIDTH_BITS-1:0]   x2_i,
    input  logic [`HEIGHT_BITS-1:0]  y1_i,
    input  logic [`HEIGHT_BITS-1:0]  y2_i,
    input  logic [`CHANNEL_BITS-1:0] r_i,
    input  logic [`CHANNEL_BITS-1:0] g_i,
    input  logic [`CHANNEL_BITS-1:0] b_i,
    output logic                     req_ready_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic [3:0]               opcode_o,
    output logic [24:0]              parameters_o,
    output logic                     command_o,
    input  logic                     stall_i
);

    localparam int WB = `WIDTH_BITS;
    localparam int HB = `HEIGHT_BITS;
    localparam int CB = `CHANNEL_BITS;
    localparam int PW = 25;

    typedef enum logic [2:0] {
        IDLE,
        SEND_XY1,
        SEND_XY2,
        SEND_DRAW,
        SEND_RST
    } state_t;

    state_t state_q, state_d;

    logic [WB-1:0] x1_q, x2_q, c1_x, c2_x;
    logic [HB-1:0] y1_q, y2_q, c1_y, c2_y;
    logic [CB-1:0] r_q, g_q, b_q;
    logic          rect_q;
    logic          c1_v, c2_v;

    logic          done_q, err_q, cmd_q;
    logic [3:0]    op_q;
    logic [PW-1:0] par_q;

    logic          done_d, err_d, cmd_d, accept;
    logic          set1, set2, clr;
    logic [3:0]    op_d;
    logic [PW-1:0] par_d;

    logic [WB-1:0] sx1, sx2;
    logic [HB-1:0] sy1, sy2;
    logic [CB-1:0] sr, sg, sb;
    logic          srect;

    logic hit1_in, hit2_in, hit2_q;

    assign hit1_in = c1_v && (c1_x == x1_i) && (c1_y == y1_i);
    assign hit2_in = c2_v && (c2_x == x2_i) && (c2_y == y2_i);
    assign hit2_q  = c2_v && (c2_x == x2_q) && (c2_y == y2_q);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        accept  = 1'b0;
        set1    = 1'b0;
        set2    = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept = 1'b1;
                    unique case (shape_i)
                        2'b00, 2'b01: begin
                            if (!hit1_in)
                                state_d = SEND_XY1;
                            else if (!hit2_in)
                                state_d = SEND_XY2;
                            else
                                state_d = SEND_DRAW;
                        end
                        2'b10:   state_d = SEND_RST;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            SEND_XY1: begin
                if (!stall_i) begin
                    set1    = 1'b1;
                    state_d = hit2_q ? SEND_DRAW : SEND_XY2;
                end
            end
            SEND_XY2: begin
                if (!stall_i) begin
                    set2    = 1'b1;
                    state_d = SEND_DRAW;
                end
            end
            SEND_DRAW: begin
                if (!stall_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            SEND_RST: begin
                if (!stall_i) begin
                    clr     = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // On the accept edge the next beat is built straight from the inputs.
    always_comb begin
        sx1   = accept ? x1_i : x1_q;
        sy1   = accept ? y1_i : y1_q;
        sx2   = accept ? x2_i : x2_q;
        sy2   = accept ? y2_i : y2_q;
        sr    = accept ? r_i : r_q;
        sg    = accept ? g_i : g_q;
        sb    = accept ? b_i : b_q;
        srect = accept ? shape_i[0] : rect_q;
        cmd_d = 1'b1;
        op_d  = 4'b0000;
        par_d = '0;
        unique case (state_d)
            SEND_XY1: begin
                op_d  = 4'b0001;
                par_d = {{(PW-WB-HB){1'b0}}, sy1, sx1};
            end
            SEND_XY2: begin
                op_d  = 4'b0010;
                par_d = {{(PW-WB-HB){1'b0}}, sy2, sx2};
            end
            SEND_DRAW: begin
                op_d  = {3'b010, srect};
                par_d = {{(PW-3*CB){1'b0}}, sr, sg, sb};
            end
            SEND_RST: begin
                op_d  = 4'b0000;
                par_d = '0;
            end
            default: cmd_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cmd_q   <= 1'b0;
            op_q    <= '0;
            par_q   <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            rect_q  <= 1'b0;
            c1_v    <= 1'b0;
            c2_v    <= 1'b0;
            c1_x    <= '0;
            c1_y    <= '0;
            c2_x    <= '0;
            c2_y    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cmd_q   <= cmd_d;
            op_q    <= op_d;
            par_q   <= par_d;
            if (accept) begin
                x1_q   <= x1_i;
                y1_q   <= y1_i;
                x2_q   <= x2_i;
                y2_q   <= y2_i;
                r_q    <= r_i;
                g_q    <= g_i;
                b_q    <= b_i;
                rect_q <= shape_i[0];
            end
            if (set1) begin
                c1_v <= 1'b1;
                c1_x <= x1_q;
                c1_y <= y1_q;
            end
            if (set2) begin
                c2_v <= 1'b1;
                c2_x <= x2_q;
                c2_y <= y2_q;
            end
            if (clr) begin
                c1_v <= 1'b0;
                c2_v <= 1'b0;
            end
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign done_o       = done_q;
    assign error_o      = err_q;
    assign command_o    = cmd_q;
    assign opcode_o     = op_q;
    assign parameters_o = par_q;

endmodule

// File: tb/tb_gpu_instruction_encoder.sv
// Random and directed requests checked against a beat-list model
// of the coordinate cache and command sequence.
`ifndef WIDTH_BITS
`define WIDTH_BITS 12
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 12
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module tb_gpu_instruction_encoder;

    localparam int WB = `WIDTH_BITS;
    localparam int HB = `HEIGHT_BITS;
    localparam int CB = `CHANNEL_BITS;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid_i;
    logic [1:0]    shape_i;
    logic [WB-1:0] x1_i, x2_i;
    logic [HB-1:0] y1_i, y2_i;
    logic [CB-1:0] r_i, g_i, b_i;
    logic          req_ready_o, done_o, error_o, command_o, stall_i;
    logic [3:0]    opcode_o;
    logic [24:0]   parameters_o;

    always #5 clk = ~clk;

    gpu_instruction_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .shape_i      (shape_i),
        .x1_i         (x1_i),
        .x2_i         (x2_i),
        .y1_i         (y1_i),
        .y2_i         (y2_i),
        .r_i          (r_i),
        .g_i          (g_i),
        .b_i          (b_i),
        .req_ready_o  (req_ready_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .opcode_o     (opcode_o),
        .parameters_o (parameters_o),
        .command_o    (command_o),
        .stall_i      (stall_i)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    typedef logic [28:0] beat_t;
    beat_t exp_q[$];

    bit c1v, c2v;
    int c1x, c1y, c2x, c2y;

    function automatic beat_t mk(input int op, input longint par);
        return {op[3:0], par[24:0]};
    endfunction

    task automatic scramble();
        shape_i = 2'($urandom_range(0, 3));
        x1_i = WB'($urandom);
        y1_i = HB'($urandom);
        x2_i = WB'($urandom);
        y2_i = HB'($urandom);
        r_i  = CB'($urandom);
        g_i  = CB'($urandom);
        b_i  = CB'($urandom);
    endtask

    // mode: 0 no stall, 1 random stall, 2 four stalls on XY2, 3 reset in XY2
    task automatic run_req(input int shape, input int x1, input int y1,
                           input int x2, input int y2, input int r,
                           input int g, input int b, input int mode);
        int  nbeats, stalls, st4;
        bit  s, fin;
        beat_t fr;
        exp_q.delete();
        if (shape <= 1) begin
            if (!(c1v && c1x == x1 && c1y == y1))
                exp_q.push_back(mk(1, longint'(y1) * (64'd1 << WB) + x1));
            if (!(c2v && c2x == x2 && c2y == y2))
                exp_q.push_back(mk(2, longint'(y2) * (64'd1 << WB) + x2));
            exp_q.push_back(mk(4 + shape, longint'(r) * (64'd1 << 2*CB)
                               + longint'(g) * (64'd1 << CB) + b));
            c1v = 1; c1x = x1; c1y = y1;
            c2v = 1; c2x = x2; c2y = y2;
        end else if (shape == 2) begin
            exp_q.push_back(mk(0, 0));
            c1v = 0;
            c2v = 0;
        end
        check("ready_before", req_ready_o, 1);
        req_valid_i = 1'b1;
        shape_i = 2'(shape);
        x1_i = WB'(x1);
        y1_i = HB'(y1);
        x2_i = WB'(x2);
        y2_i = HB'(y2);
        r_i  = CB'(r);
        g_i  = CB'(g);
        b_i  = CB'(b);
        @(negedge clk);
        req_valid_i = 1'b0;
        scramble();
        if (shape == 3) begin
            check("err_pulse", error_o, 1);
            check("err_cmd", command_o, 0);
            check("err_ready", req_ready_o, 1);
            @(negedge clk);
            check("err_once", error_o, 0);
            check("err_cmd2", command_o, 0);
            check("err_done", done_o, 0);
            check("err_ready2", req_ready_o, 1);
            return;
        end
        nbeats = exp_q.size();
        stalls = 0;
        st4 = 0;
        fin = 0;
        for (int c = 1; c <= 60 && !fin; c++) begin
            stall_i = 1'b0;
            if (exp_q.size() != 0) begin
                fr = exp_q[0];
                check("cmd", command_o, 1);
                check("busy_ready", req_ready_o, 0);
                check("opcode", opcode_o, fr[28:25]);
                check("params", parameters_o, fr[24:0]);
                check("no_early_done", done_o, 0);
                if (mode == 3 && fr[28:25] == 4'd2) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    check("rst_cmd", command_o, 0);
                    check("rst_ready", req_ready_o, 1);
                    check("rst_done", done_o, 0);
                    check("rst_op", opcode_o, 0);
                    check("rst_par", parameters_o, 0);
                    c1v = 0;
                    c2v = 0;
                    @(negedge clk);
                    check("rst_done2", done_o, 0);
                    check("rst_cmd2", command_o, 0);
                    return;
                end
                if (mode == 1)
                    s = ($urandom_range(0, 2) == 0);
                else
                    s = (mode == 2 && fr[28:25] == 4'd2 && st4 < 4);
                if (s) begin
                    stalls++;
                    st4++;
                end else begin
                    void'(exp_q.pop_front());
                end
                stall_i = s;
                req_valid_i = 1'($urandom_range(0, 1));
            end else begin
                check("done", done_o, 1);
                check("latency", c, nbeats + stalls + 1);
                check("idle_cmd", command_o, 0);
                check("idle_ready", req_ready_o, 1);
                req_valid_i = 1'b0;
                fin = 1;
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) check("timeout", 0, 1);
        req_valid_i = 1'b0;
        stall_i = 1'b0;
    endtask

    initial begin
        int sel;
        rst = 1'b1;
        req_valid_i = 1'b0;
        stall_i = 1'b0;
        scramble();
        c1v = 0;
        c2v = 0;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready_o, 1);
        check("rst_cmd", command_o, 0);
        check("rst_op", opcode_o, 0);
        check("rst_par", parameters_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", error_o, 0);
        rst = 1'b0;
        @(negedge clk);

        run_req(0, 5, 3, 9, 7, 1, 2, 3, 0);
        run_req(1, 5, 3, 9, 7, 1, 2, 3, 0);
        run_req(2, 0, 0, 0, 0, 0, 0, 0, 0);
        run_req(1, 5, 3, 9, 7, 1, 2, 3, 0);
        run_req(0, 10, 11, 12, 13, 4, 5, 6, 2);
        run_req(3, 1, 1, 1, 1, 1, 1, 1, 0);
        run_req(0, 20, 21, 22, 23, 7, 7, 7, 3);
        run_req(0, 20, 21, 22, 23, 7, 7, 7, 0);
        run_req(0, 20, 21, 30, 31, 8, 9, 10, 0);

        repeat (300) begin
            sel = $urandom_range(0, 9);
            run_req(sel < 4 ? 0 : sel < 8 ? 1 : sel == 8 ? 2 : 3,
                    $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
